// File: rtl/writeback_unit_pkg.sv
// Writeback unit shared definitions.
// Default widths, queue sizing and issue-source encoding.
package writeback_unit_pkg;

  localparam int unsigned REG_WIDTH    = 32;
  localparam int unsigned REG_DEPTH    = 32;
  localparam int unsigned FIFO_DEPTH_D = 4;
  localparam int unsigned STARVE_LIM_D = 8;
  localparam int unsigned REG_ZERO     = 0;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_STARVE,
    SEL_ALU,
    SEL_LOAD
  } wb_sel_e;

endpackage

// File: rtl/writeback_unit_fifo.sv
// Load-result queue: circular buffer with occupancy count.
// Exposes entries in age order so the owner can see what is pending.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 37,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] peek_o [DEPTH]
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  for (genvar g = 0; g < DEPTH; g++) begin : g_peek
    assign peek_o[g] = mem_q[rd_ptr_q + PW'(g)];
  end

  // Storage holds no reset; validity comes from the count.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally; count tracks push/pop balance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback arbiter: ALU results bypass, load results queue.
// A starve counter guarantees the queue head eventually issues.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH = REG_WIDTH,
  parameter int unsigned REGISTER_DEPTH = REG_DEPTH,
  parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_D,
  parameter int unsigned STARVE_LIMIT   = STARVE_LIM_D,
  localparam int unsigned AW = $clog2(REGISTER_DEPTH)
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      ALU_VALID,
  output logic                      ALU_READY,
  input  logic [AW-1:0]             ALU_ADDRESS,
  input  logic [REGISTER_WIDTH-1:0] ALU_DATA,
  input  logic                      LOAD_VALID,
  output logic                      LOAD_READY,
  input  logic [AW-1:0]             LOAD_ADDRESS,
  input  logic [REGISTER_WIDTH-1:0] LOAD_DATA,
  output logic [AW-1:0]             RD_ADDRESS,
  output logic [REGISTER_WIDTH-1:0] RD_DATA,
  output logic                      RD_WRITE_EN,
  output logic [REGISTER_DEPTH-1:0] PENDING_MASK
);

  localparam int unsigned EW = AW + REGISTER_WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic                      push, pop, full, empty;
  logic [CW-1:0]             count;
  logic [EW-1:0]             head;
  logic [EW-1:0]             peek [FIFO_DEPTH];
  logic [SW-1:0]             starve_q, starve_d;
  logic                      starve_hit, alu_live;
  wb_sel_e                   sel;
  logic                      we_q, we_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [REGISTER_WIDTH-1:0] data_q, data_d;

  assign alu_live   = ALU_VALID && (ALU_ADDRESS != AW'(REG_ZERO));
  assign starve_hit = !empty && (starve_q == SW'(STARVE_LIMIT));
  assign ALU_READY  = !starve_hit;
  assign LOAD_READY = !full;
  assign push = LOAD_VALID && !full &&
                (LOAD_ADDRESS != AW'(REG_ZERO));
  assign pop  = (sel == SEL_STARVE) || (sel == SEL_LOAD);

  wb_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EW)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .push_i (push),
    .pop_i  (pop),
    .data_i ({LOAD_ADDRESS, LOAD_DATA}),
    .data_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count),
    .peek_o (peek)
  );

  // Issue priority: starved head, then ALU, then queue head.
  always_comb begin
    sel = SEL_NONE;
    if (starve_hit)  sel = SEL_STARVE;
    else if (alu_live) sel = SEL_ALU;
    else if (!empty) sel = SEL_LOAD;
  end

  // Next write command from the selected source.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    unique case (sel)
      SEL_STARVE, SEL_LOAD: begin
        we_d   = 1'b1;
        addr_d = head[REGISTER_WIDTH +: AW];
        data_d = head[REGISTER_WIDTH-1:0];
      end
      SEL_ALU: begin
        we_d   = 1'b1;
        addr_d = ALU_ADDRESS;
        data_d = ALU_DATA;
      end
      default: ;
    endcase
  end

  // Head wait time: cleared on issue or empty, saturating.
  always_comb begin
    starve_d = starve_q;
    if (empty || pop)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + SW'(1);
  end

  // Registers pending writes from queue and output stage.
  always_comb begin
    PENDING_MASK = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (CW'(i) < count)
        PENDING_MASK[peek[i][REGISTER_WIDTH +: AW]] = 1'b1;
    end
    if (we_q) PENDING_MASK[addr_q] = 1'b1;
    PENDING_MASK[0] = 1'b0;
  end

  // Output command register and starve counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      starve_q <= '0;
    end else begin
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      starve_q <= starve_d;
    end
  end

  assign RD_WRITE_EN = we_q;
  assign RD_ADDRESS  = addr_q;
  assign RD_DATA     = data_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit.
// Vector table plus starvation, full-queue and reset sequences.
module tb_writeback_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        ALU_VALID = 1'b0;
  logic        ALU_READY;
  logic [4:0]  ALU_ADDRESS = '0;
  logic [31:0] ALU_DATA = '0;
  logic        LOAD_VALID = 1'b0;
  logic        LOAD_READY;
  logic [4:0]  LOAD_ADDRESS = '0;
  logic [31:0] LOAD_DATA = '0;
  logic [4:0]  RD_ADDRESS;
  logic [31:0] RD_DATA;
  logic        RD_WRITE_EN;
  logic [31:0] PENDING_MASK;

  int passed = 0;
  int total  = 0;

  writeback_unit dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .ALU_VALID   (ALU_VALID),
    .ALU_READY   (ALU_READY),
    .ALU_ADDRESS (ALU_ADDRESS),
    .ALU_DATA    (ALU_DATA),
    .LOAD_VALID  (LOAD_VALID),
    .LOAD_READY  (LOAD_READY),
    .LOAD_ADDRESS(LOAD_ADDRESS),
    .LOAD_DATA   (LOAD_DATA),
    .RD_ADDRESS  (RD_ADDRESS),
    .RD_DATA     (RD_DATA),
    .RD_WRITE_EN (RD_WRITE_EN),
    .PENDING_MASK(PENDING_MASK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] mask;
  } vec_t;

  vec_t vt [13];

  function automatic vec_t mk(
    input logic av, input logic [4:0] aa, input logic [31:0] ad,
    input logic lv, input logic [4:0] la, input logic [31:0] ld,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic [31:0] mask);
    vec_t r;
    r.av = av; r.aa = aa; r.ad = ad;
    r.lv = lv; r.la = la; r.ld = ld;
    r.we = we; r.wa = wa; r.wd = wd; r.mask = mask;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_we"},   {31'd0, RD_WRITE_EN}, 32'd0);
    chk({tag, "_addr"}, {27'd0, RD_ADDRESS}, 32'd0);
    chk({tag, "_data"}, RD_DATA, 32'd0);
    chk({tag, "_mask"}, PENDING_MASK, 32'd0);
    chk({tag, "_lrdy"}, {31'd0, LOAD_READY}, 32'd1);
    chk({tag, "_ardy"}, {31'd0, ALU_READY}, 32'd1);
  endtask

  initial begin
    vt[0]  = mk(1'b1, 5'd5,  32'h1234, 1'b0, 5'd0, 32'h0,
                1'b1, 5'd5,  32'h1234, 32'h0000_0020);
    vt[1]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,
                1'b0, 5'd0,  32'h0,    32'h0);
    vt[2]  = mk(1'b1, 5'd0,  32'hFFFF, 1'b1, 5'd0, 32'hEEEE,
                1'b0, 5'd0,  32'h0,    32'h0);
    vt[3]  = mk(1'b1, 5'd3,  32'hBBBB, 1'b1, 5'd3, 32'hAAAA,
                1'b1, 5'd3,  32'hBBBB, 32'h0000_0008);
    vt[4]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,
                1'b1, 5'd3,  32'hAAAA, 32'h0000_0008);
    vt[5]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,
                1'b0, 5'd0,  32'h0,    32'h0);
    vt[6]  = mk(1'b0, 5'd0,  32'h0,    1'b1, 5'd9, 32'h99,
                1'b0, 5'd0,  32'h0,    32'h0000_0200);
    vt[7]  = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,
                1'b1, 5'd9,  32'h99,   32'h0000_0200);
    vt[8]  = mk(1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                1'b1, 5'd31, 32'hDEADBEEF, 32'h8000_0000);
    vt[9]  = mk(1'b1, 5'd4,  32'h44,   1'b1, 5'd2, 32'h22,
                1'b1, 5'd4,  32'h44,   32'h0000_0014);
    vt[10] = mk(1'b1, 5'd6,  32'h66,   1'b0, 5'd0, 32'h0,
                1'b1, 5'd6,  32'h66,   32'h0000_0044);
    vt[11] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,
                1'b1, 5'd2,  32'h22,   32'h0000_0004);
    vt[12] = mk(1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,
                1'b0, 5'd0,  32'h0,    32'h0);

    // Asynchronous reset before any clock edge.
    #1 RST_N = 1'b0;
    #1 chk_reset_outs("por");
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    step();

    // Table vectors: one cycle each, outputs checked after the edge.
    for (int i = 0; i < 13; i++) begin
      ALU_VALID    = vt[i].av;
      ALU_ADDRESS  = vt[i].aa;
      ALU_DATA     = vt[i].ad;
      LOAD_VALID   = vt[i].lv;
      LOAD_ADDRESS = vt[i].la;
      LOAD_DATA    = vt[i].ld;
      step();
      chk($sformatf("v%0d_we", i), {31'd0, RD_WRITE_EN},
          {31'd0, vt[i].we});
      if (vt[i].we) begin
        chk($sformatf("v%0d_addr", i), {27'd0, RD_ADDRESS},
            {27'd0, vt[i].wa});
        chk($sformatf("v%0d_data", i), RD_DATA, vt[i].wd);
      end
      chk($sformatf("v%0d_mask", i), PENDING_MASK, vt[i].mask);
      chk($sformatf("v%0d_ardy", i), {31'd0, ALU_READY}, 32'd1);
      chk($sformatf("v%0d_lrdy", i), {31'd0, LOAD_READY}, 32'd1);
    end
    ALU_VALID  = 1'b0;
    LOAD_VALID = 1'b0;
    step();

    // Starvation: ALU to x7 held while loads x1..x5 queue up.
    ALU_VALID    = 1'b1;
    ALU_ADDRESS  = 5'd7;
    ALU_DATA     = 32'h7777;
    LOAD_VALID   = 1'b1;
    LOAD_ADDRESS = 5'd1;
    LOAD_DATA    = 32'h101;
    for (int e = 1; e <= 15; e++) begin
      logic fire;
      fire = LOAD_VALID && LOAD_READY;
      step();
      if (fire) begin
        if (LOAD_ADDRESS == 5'd5) LOAD_VALID = 1'b0;
        else begin
          LOAD_ADDRESS = LOAD_ADDRESS + 5'd1;
          LOAD_DATA    = LOAD_DATA + 32'd1;
        end
      end
      case (e)
        1: chk("st_e1_addr", {27'd0, RD_ADDRESS}, 32'd7);
        3: chk("st_e3_lrdy", {31'd0, LOAD_READY}, 32'd1);
        4: begin
          chk("st_full_lrdy", {31'd0, LOAD_READY}, 32'd0);
          chk("st_full_mask", PENDING_MASK, 32'h0000_009E);
        end
        8: chk("st_e8_ardy", {31'd0, ALU_READY}, 32'd1);
        9: begin
          chk("st_e9_ardy", {31'd0, ALU_READY}, 32'd0);
          chk("st_e9_addr", {27'd0, RD_ADDRESS}, 32'd7);
          chk("st_e9_lrdy", {31'd0, LOAD_READY}, 32'd0);
        end
        10: begin
          chk("st_x1_we",   {31'd0, RD_WRITE_EN}, 32'd1);
          chk("st_x1_addr", {27'd0, RD_ADDRESS}, 32'd1);
          chk("st_x1_data", RD_DATA, 32'h101);
          chk("st_pushpop_mask", PENDING_MASK, 32'h0000_001E);
          chk("st_e10_ardy", {31'd0, ALU_READY}, 32'd1);
          chk("st_e10_lrdy", {31'd0, LOAD_READY}, 32'd1);
          ALU_VALID = 1'b0;
        end
        11: begin
          chk("st_x2_addr", {27'd0, RD_ADDRESS}, 32'd2);
          chk("st_e11_mask", PENDING_MASK, 32'h0000_003C);
        end
        12: chk("st_x3_addr", {27'd0, RD_ADDRESS}, 32'd3);
        13: chk("st_x4_addr", {27'd0, RD_ADDRESS}, 32'd4);
        14: begin
          chk("st_x5_addr", {27'd0, RD_ADDRESS}, 32'd5);
          chk("st_x5_data", RD_DATA, 32'h105);
          chk("st_e14_mask", PENDING_MASK, 32'h0000_0020);
        end
        15: begin
          chk("st_idle_we", {31'd0, RD_WRITE_EN}, 32'd0);
          chk("st_idle_mask", PENDING_MASK, 32'd0);
        end
        default: ;
      endcase
    end

    // Reset mid-cycle with three loads queued behind an ALU stream.
    ALU_VALID    = 1'b1;
    ALU_ADDRESS  = 5'd8;
    ALU_DATA     = 32'h88;
    LOAD_VALID   = 1'b1;
    LOAD_ADDRESS = 5'd10;
    LOAD_DATA    = 32'hA0;
    step();
    LOAD_ADDRESS = 5'd11;
    step();
    LOAD_ADDRESS = 5'd12;
    step();
    ALU_VALID  = 1'b0;
    LOAD_VALID = 1'b0;
    chk("rst_pre_mask", PENDING_MASK, 32'h0000_1D00);
    #2 RST_N = 1'b0;
    #1 chk_reset_outs("mid");
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("post_rst%0d_we", c), {31'd0, RD_WRITE_EN}, 32'd0);
      chk($sformatf("post_rst%0d_mask", c), PENDING_MASK, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameters: REGISTER_WIDTH, 32, data width; REGISTER_DEPTH, 32, register count; FIFO_DEPTH, 4, load-result queue entries (power of 2); STARVE_LIMIT, 8, max cycles the queue head waits.
REQ-002 SHALL have ports: CLK  in  1  sole clock, all state on posedge.
REQ-003 RST_N  in  1  asynchronous, active-low reset.
REQ-004 ALU_VALID  in  1  ALU result present; ALU_READY  out  1  ALU result accepted this cycle.
REQ-005 ALU_ADDRESS  in  $clog2(REGISTER_DEPTH)  destination; ALU_DATA  in  REGISTER_WIDTH  result.
REQ-006 LOAD_VALID  in  1  load result present; LOAD_READY  out  1  queue can accept.
REQ-007 LOAD_ADDRESS  in  $clog2(REGISTER_DEPTH)  destination; LOAD_DATA  in  REGISTER_WIDTH  loaded value.
REQ-008 RD_ADDRESS, RD_DATA, RD_WRITE_EN  out  widths as register-file write port  registered write command.
REQ-009 PENDING_MASK  out  REGISTER_DEPTH  bit i set while a write to register i is queued or held in the output register.

Function
REQ-010 A transfer SHALL occur on a source when VALID and READY are both high at posedge; sources SHALL hold address/data until transfer.
REQ-011 LOAD_READY SHALL equal not-full; no enqueue when full, even if a dequeue occurs the same cycle.
REQ-012 Transfers with destination 0 SHALL be accepted and discarded (no enqueue, no write, no PENDING_MASK bit).
REQ-013 Each cycle the output register SHALL load, in priority: (a) queue head if starve counter = STARVE_LIMIT; (b) ALU result if ALU_VALID and nonzero destination; (c) queue head if non-empty; (d) else RD_WRITE_EN <= 0.
REQ-014 ALU_READY SHALL be low only in cycles where case (a) applies; otherwise high.
REQ-015 ALU results SHALL appear on RD_* one cycle after transfer; load results SHALL take at least two cycles (enqueue, then issue), never bypassing the queue.
REQ-016 The queue SHALL be FIFO-ordered; pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width $clog2(FIFO_DEPTH)+1.
REQ-017 Simultaneous enqueue and dequeue when non-full SHALL leave occupancy unchanged.
REQ-018 Starve counter SHALL increment each cycle the queue is non-empty and the head is not issued; clear on head issue or empty queue; saturate at STARVE_LIMIT.
REQ-019 PENDING_MASK SHALL be combinational OR of decoded valid queue entries and the output register when RD_WRITE_EN is high; bit 0 always 0.
REQ-020 RD_* SHALL be stable from posedge through the following negedge so the register file samples them on that negedge.
REQ-021 Writes to the same register SHALL reach RD_* in acceptance order within each source; cross-source order follows REQ-013.

Reset
REQ-022 RST_N low SHALL asynchronously clear: RD_WRITE_EN=0, RD_ADDRESS=0, RD_DATA=0, queue occupancy and pointers=0, starve counter=0.
REQ-023 Resulting outputs during reset: LOAD_READY=1, ALU_READY=1, PENDING_MASK=0; queued entries mid-operation SHALL be dropped, never written.
REQ-024 Queue data storage SHALL need no reset.

Structure
REQ-025 Default widths, STARVE_LIMIT, and the register-0 address constant SHALL live in the shared core package.
REQ-026 The queue SHALL be one sub-module, wb_fifo (parameterised depth/width, push/pop/full/empty/count), instantiated once.

Verification
REQ-027 Reset then ALU_VALID=1, ALU_ADDRESS=5, ALU_DATA=0x1234 for one cycle -> next cycle RD_WRITE_EN=1, RD_ADDRESS=5, RD_DATA=0x1234, PENDING_MASK[5]=1; cycle after RD_WRITE_EN=0.
REQ-028 Five back-to-back loads to x1..x5 with ALU_VALID held high to x7 -> LOAD_READY low after 4 enqueues; at 8th waiting cycle ALU_READY=0 and x1 written; order x1..x5 preserved.
REQ-029 ALU and load both to x0 -> both accepted, RD_WRITE_EN never asserts, PENDING_MASK stays 0.
REQ-030 Load to x3 (0xAAAA) and ALU to x3 (0xBBBB) same cycle -> RD writes 0xBBBB then 0xAAAA on consecutive cycles.
REQ-031 Queue holding 3 entries, assert RST_N=0 mid-cycle -> outputs clear immediately; after release no write of the dropped entries occurs.
REQ-032 Fill queue to 4, pop and push same cycle -> push refused (LOAD_READY=0), occupancy 3 next cycle.
